booth_multiplier_seq: RTL

- Sequential radix-2 Booth multiplier. It is the inverse-operation companion to the non-restoring divider, sharing the same operand width and the clk/reset conventions.
- Multiplies two n-bit operands, signed or unsigned per transaction, producing a 2n-bit product over n+1 iterations.
- Uses a valid/ready handshake on both input and output, so it can sit in a datapath or a divide/multiply round-trip checker (quotient*divisor + remainder == dividend).

---
 rtl/booth_mul_pkg.sv | 22 ++
 rtl/booth_multiplier_seq_booth_step.sv | 34 +++
 rtl/booth_multiplier_seq.sv | 91 +++++++++
 3 files changed

// File: rtl/booth_mul_pkg.sv
// Shared types and helpers for the sequential radix-2 Booth multiplier.
package booth_mul_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    typedef enum logic [1:0] {NOP, ADD, SUB} booth_op_t;

    // Radix-2 Booth recoding of the current multiplier bit pair.
    function automatic booth_op_t booth_op(input logic qx0, input logic q_m1);
        case ({qx0, q_m1})
            2'b01:   return ADD;
            2'b10:   return SUB;
            default: return NOP;
        endcase
    endfunction

    // Iteration counter width: must hold n+1.
    function automatic int cnt_width(input int w);
        return $clog2(w + 2);
    endfunction

endpackage

// File: rtl/booth_multiplier_seq_booth_step.sv
// One Booth iteration: conditional add/sub of Mx into A, then an arithmetic
// right shift of the concatenation {A, Qx, q_m1}.
module booth_step
    import booth_mul_pkg::*;
#(
    parameter int n = 64
) (
    input  logic [n+1:0] a,
    input  logic [n+1:0] mx,
    input  logic [n:0]   qx,
    input  logic         q_m1,
    output logic [n+1:0] a_nxt,
    output logic [n:0]   qx_nxt,
    output logic         q_m1_nxt
);

    logic [n+1:0] sum;

    // Add, subtract or pass A according to the recoded bit pair.
    always_comb begin
        sum = a;
        case (booth_op(qx[0], q_m1))
            ADD:     sum = a + mx;
            SUB:     sum = a - mx;
            default: sum = a;
        endcase
    end

    // Shift right by one, replicating the accumulator MSB.
    assign a_nxt    = {sum[n+1], sum[n+1:1]};
    assign qx_nxt   = {sum[0], qx[n:1]};
    assign q_m1_nxt = qx[0];

endmodule

// File: rtl/booth_multiplier_seq.sv
// Sequential radix-2 Booth multiplier, n+1 iterations per product, with
// valid/ready handshakes on operands and result.
module booth_multiplier_seq
    import booth_mul_pkg::*;
#(
    parameter int n = 64
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [n-1:0]   multiplicand,
    input  logic [n-1:0]   multiplier,
    input  logic           is_signed,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*n-1:0] product,
    output logic           busy
);

    localparam int CW = cnt_width(n);

    state_t        state;
    logic [n+1:0]  a;
    logic [n+1:0]  mx;
    logic [n:0]    qx;
    logic          q_m1;
    logic [CW-1:0] cnt;

    logic [n+1:0]  a_nxt;
    logic [n:0]    qx_nxt;
    logic          q_m1_nxt;

    booth_step #(.n(n)) u_step (
        .a        (a),
        .mx       (mx),
        .qx       (qx),
        .q_m1     (q_m1),
        .a_nxt    (a_nxt),
        .qx_nxt   (qx_nxt),
        .q_m1_nxt (q_m1_nxt)
    );

    // Handshake flags are pure decodes of the state register.
    assign in_ready  = (state == IDLE);
    assign busy      = (state == RUN);
    assign out_valid = (state == DONE);

    // FSM: capture operands, iterate n+1 times, hold the product until taken.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            a       <= '0;
            mx      <= '0;
            qx      <= '0;
            q_m1    <= 1'b0;
            cnt     <= '0;
            product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a     <= '0;
                        // Extra top bits let the accumulator absorb the full
                        // Booth range for both signed and unsigned operands.
                        mx    <= {{2{is_signed & multiplicand[n-1]}}, multiplicand};
                        qx    <= {is_signed & multiplier[n-1], multiplier};
                        q_m1  <= 1'b0;
                        cnt   <= CW'(n + 1);
                        state <= RUN;
                    end
                end
                RUN: begin
                    a    <= a_nxt;
                    qx   <= qx_nxt;
                    q_m1 <= q_m1_nxt;
                    cnt  <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        product <= {a_nxt[n-2:0], qx_nxt};
                        state   <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
